// File: rtl/filter_gin_receiver_pkg.sv
// Shared types and constants for the filter GIN receiver.
// Optional broadcast tag matching is enabled by defining FILTER_GIN_BROADCAST_EN.
package filter_gin_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SEND   = 2'd2
   } state_t;

   // Number of output weights packed into one GIN word.
   function automatic int ratio(input int data_in_width, input int data_out_width);
      return data_in_width / data_out_width;
   endfunction

   // Beat counter width; a single-beat word still needs a 1-bit counter.
   function automatic int beat_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   // All-ones broadcast tags; sliced down to the actual tag width where used.
   localparam logic [31:0] BCAST_ROW = '1;
   localparam logic [31:0] BCAST_COL = '1;

endpackage

// File: rtl/filter_gin_receiver_tag_matcher.sv
// Combinational row/column tag matcher producing the per-PE delivery mask.
// When FILTER_GIN_BROADCAST_EN is defined, all-ones row/col tags act as wildcards.
module gin_tag_matcher
   import filter_gin_pkg::*;
#(
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_PE        = 14
) (
   input  logic [ROW_TAG_WIDTH-1:0]        row_tag,
   input  logic [COL_TAG_WIDTH-1:0]        col_tag,
   input  logic [ROW_TAG_WIDTH-1:0]        row_id,
   input  logic [NUM_PE*COL_TAG_WIDTH-1:0] col_ids,
   output logic [NUM_PE-1:0]               mask
);

`ifdef FILTER_GIN_BROADCAST_EN
   localparam bit BCAST_EN = 1'b1;
`else
   localparam bit BCAST_EN = 1'b0;
`endif

   logic row_hit;
   logic col_bcast;

   // Row matches this row's ID, or the broadcast row tag when wildcards are enabled.
   assign row_hit   = (row_tag == row_id) ||
                      (BCAST_EN && (row_tag == BCAST_ROW[ROW_TAG_WIDTH-1:0]));
   assign col_bcast = BCAST_EN && (col_tag == BCAST_COL[COL_TAG_WIDTH-1:0]);

   // One compare per PE; duplicate column IDs naturally yield a multicast mask.
   generate
      for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
         assign mask[gi] = row_hit &&
                           (col_bcast || (col_tag == col_ids[gi*COL_TAG_WIDTH +: COL_TAG_WIDTH]));
      end
   endgenerate

endmodule

// File: rtl/filter_gin_receiver.sv
// Filter GIN receiver for one PE row: pops tagged 64-bit words from FWFT FIFOs,
// matches tags against the row/column IDs and multicasts the unpacked weights
// to every matching PE under per-PE backpressure.
// Optional feature macro: FILTER_GIN_BROADCAST_EN (all-ones tags act as wildcards).
module filter_gin_receiver
   import filter_gin_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = 64,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int ROW_TAG_WIDTH  = 4,
   parameter int COL_TAG_WIDTH  = 4,
   parameter int NUM_PE         = 14,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ROW_TAG_WIDTH-1:0]        row_id,
   input  logic [NUM_PE*COL_TAG_WIDTH-1:0] col_ids,
   input  logic                            gin_fifo_empty,
   input  logic [DATA_IN_WIDTH-1:0]        gin_data,
   input  logic                            tags_fifo_empty,
   input  logic [ROW_TAG_WIDTH-1:0]        row_tag,
   input  logic [COL_TAG_WIDTH-1:0]        col_tag,
   output logic                            re_from_gin_fifo,
   input  logic [NUM_PE-1:0]               pe_ready,
   output logic [NUM_PE-1:0]               pe_we,
   output logic [DATA_OUT_WIDTH-1:0]       pe_data,
   output logic                            busy,
   output logic [CNT_WIDTH-1:0]            delivered_count,
   output logic [CNT_WIDTH-1:0]            dropped_count
);

   localparam int RATIO  = ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
   localparam int BEAT_W = beat_width(RATIO);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

   state_t                    state_reg;
   logic [DATA_IN_WIDTH-1:0]  word_reg;
   logic [ROW_TAG_WIDTH-1:0]  row_tag_reg;
   logic [COL_TAG_WIDTH-1:0]  col_tag_reg;
   logic [NUM_PE-1:0]         mask_reg;
   logic [BEAT_W-1:0]         beat_reg;
   logic [DATA_OUT_WIDTH-1:0] pe_data_reg;
   logic [CNT_WIDTH-1:0]      delivered_reg;
   logic [CNT_WIDTH-1:0]      dropped_reg;

   logic [NUM_PE-1:0]         mask_next;
   logic                      pop;
   logic                      go;
   logic                      write_beat;
   logic [DATA_OUT_WIDTH-1:0] slices [RATIO];
   logic [DATA_OUT_WIDTH-1:0] beat_data;

   gin_tag_matcher #(
      .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
      .COL_TAG_WIDTH (COL_TAG_WIDTH),
      .NUM_PE        (NUM_PE)
   ) u_matcher (
      .row_tag (row_tag_reg),
      .col_tag (col_tag_reg),
      .row_id  (row_id),
      .col_ids (col_ids),
      .mask    (mask_next)
   );

   // Split the latched word into weights, least significant slice first.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
         assign slices[gi] = word_reg[gi*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
      end
   endgenerate

   assign beat_data = slices[beat_reg];

   // Pop both FWFT FIFOs together only when idle and both heads are valid.
   assign pop = (state_reg == IDLE) && !gin_fifo_empty && !tags_fifo_empty;

   // Only targeted PEs can stall a beat; untargeted ready lines are masked off.
   assign go         = &(pe_ready | ~mask_reg);
   assign write_beat = (state_reg == SEND) && go;

   assign re_from_gin_fifo = pop;
   assign pe_we            = write_beat ? mask_reg : '0;
   assign pe_data          = write_beat ? beat_data : pe_data_reg;
   assign busy             = (state_reg != IDLE);
   assign delivered_count  = delivered_reg;
   assign dropped_count    = dropped_reg;

   // Receive FSM: latch on pop, decode the mask, then stream the beats out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         word_reg      <= '0;
         row_tag_reg   <= '0;
         col_tag_reg   <= '0;
         mask_reg      <= '0;
         beat_reg      <= '0;
         pe_data_reg   <= '0;
         delivered_reg <= '0;
         dropped_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  word_reg    <= gin_data;
                  row_tag_reg <= row_tag;
                  col_tag_reg <= col_tag;
                  state_reg   <= DECODE;
               end
            end
            DECODE: begin
               mask_reg <= mask_next;
               if (mask_next == '0) begin
                  dropped_reg <= dropped_reg + 1'b1;
                  state_reg   <= IDLE;
               end else begin
                  beat_reg  <= '0;
                  state_reg <= SEND;
               end
            end
            SEND: begin
               if (go) begin
                  pe_data_reg <= beat_data;
                  beat_reg    <= beat_reg + 1'b1;
                  if (beat_reg == LAST_BEAT) begin
                     delivered_reg <= delivered_reg + 1'b1;
                     state_reg     <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filter_gin_receiver.sv
// Self-checking bench for filter_gin_receiver: directed scenarios followed by
// random traffic, compared cycle by cycle against a queue-based reference model.
module tb_filter_gin_receiver;

   localparam int DIW   = 64;
   localparam int DOW   = 16;
   localparam int RW    = 4;
   localparam int CW    = 4;
   localparam int NP    = 14;
   localparam int CNTW  = 16;
   localparam int RATIO = DIW / DOW;

`ifdef FILTER_GIN_BROADCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   typedef struct packed {
      logic [RW-1:0] r;
      logic [CW-1:0] c;
   } tag_t;

   typedef struct packed {
      logic [NP-1:0]  mask;
      logic [DOW-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [RW-1:0]     row_id;
   logic [CW-1:0]     col_arr [NP];
   logic [NP*CW-1:0]  col_ids;
   logic              gin_fifo_empty;
   logic [DIW-1:0]    gin_data;
   logic              tags_fifo_empty;
   logic [RW-1:0]     row_tag;
   logic [CW-1:0]     col_tag;
   logic              re_from_gin_fifo;
   logic [NP-1:0]     pe_ready;
   logic [NP-1:0]     pe_we;
   logic [DOW-1:0]    pe_data;
   logic              busy;
   logic [CNTW-1:0]   delivered_count;
   logic [CNTW-1:0]   dropped_count;

   // Bench-side FIFOs and reference model state
   logic [DIW-1:0]    data_q [$];
   tag_t              tag_q [$];
   logic [DIW-1:0]    gen_data [$];
   tag_t              gen_tag [$];
   bit                m_decode_pending;
   logic [DIW-1:0]    m_word;
   tag_t              m_tag;
   beat_t             m_beats [$];
   logic [DOW-1:0]    m_last_data;
   logic [CNTW-1:0]   m_delivered;
   logic [CNTW-1:0]   m_dropped;
   int                word_no;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      col_ids = '0;
      for (int i = 0; i < NP; i++) col_ids[i*CW +: CW] = col_arr[i];
   end

   filter_gin_receiver #(
      .DATA_IN_WIDTH  (DIW),
      .DATA_OUT_WIDTH (DOW),
      .ROW_TAG_WIDTH  (RW),
      .COL_TAG_WIDTH  (CW),
      .NUM_PE         (NP),
      .CNT_WIDTH      (CNTW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .row_id           (row_id),
      .col_ids          (col_ids),
      .gin_fifo_empty   (gin_fifo_empty),
      .gin_data         (gin_data),
      .tags_fifo_empty  (tags_fifo_empty),
      .row_tag          (row_tag),
      .col_tag          (col_tag),
      .re_from_gin_fifo (re_from_gin_fifo),
      .pe_ready         (pe_ready),
      .pe_we            (pe_we),
      .pe_data          (pe_data),
      .busy             (busy),
      .delivered_count  (delivered_count),
      .dropped_count    (dropped_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mask straight from the matching rule: row equal (or wildcard), column equal (or wildcard).
   function automatic logic [NP-1:0] model_mask(input tag_t t);
      logic [NP-1:0] m;
      bit row_ok;
      row_ok = (t.r == row_id) || (BCAST && (t.r == 4'hF));
      for (int i = 0; i < NP; i++)
         m[i] = row_ok && ((t.c == col_arr[i]) || (BCAST && (t.c == 4'hF)));
      return m;
   endfunction

   task automatic drive_heads();
      gin_fifo_empty  = (data_q.size() == 0);
      tags_fifo_empty = (tag_q.size() == 0);
      gin_data        = gin_fifo_empty ? '0 : data_q[0];
      row_tag         = tags_fifo_empty ? '0 : tag_q[0].r;
      col_tag         = tags_fifo_empty ? '0 : tag_q[0].c;
   endtask

   function automatic bit model_in_flight();
      return m_decode_pending || (m_beats.size() != 0);
   endfunction

   // One clock: compare outputs against the model, then advance the model past the edge.
   task automatic step();
      bit             exp_pop;
      bit             in_flight;
      bit             go;
      logic [NP-1:0]  exp_we;
      logic [DOW-1:0] exp_data;
      logic [NP-1:0]  msk;
      drive_heads();
      #1;
      in_flight = model_in_flight();
      exp_pop   = !in_flight && (data_q.size() != 0) && (tag_q.size() != 0);
      go        = 1'b0;
      exp_we    = '0;
      exp_data  = m_last_data;
      if (m_beats.size() != 0) begin
         go = &(pe_ready | ~m_beats[0].mask);
         if (go) begin
            exp_we   = m_beats[0].mask;
            exp_data = m_beats[0].data;
         end
      end
      check("pop", re_from_gin_fifo, exp_pop);
      check("pe_we", pe_we, exp_we);
      check("pe_data", pe_data, exp_data);
      check("busy", busy, in_flight);
      check("delivered_count", delivered_count, m_delivered);
      check("dropped_count", dropped_count, m_dropped);
      @(posedge clk);
      #1;
      if (exp_pop) begin
         m_word           = data_q.pop_front();
         m_tag            = tag_q.pop_front();
         m_decode_pending = 1'b1;
      end else if (m_decode_pending) begin
         m_decode_pending = 1'b0;
         msk = model_mask(m_tag);
         word_no++;
         if (msk == '0) begin
            m_dropped++;
            $display("word %0d: data=%h tags=(%h,%h) dropped", word_no, m_word, m_tag.r, m_tag.c);
         end else begin
            for (int b = 0; b < RATIO; b++) m_beats.push_back({msk, m_word[b*DOW +: DOW]});
            $display("word %0d: data=%h tags=(%h,%h) mask=%h queued", word_no, m_word, m_tag.r, m_tag.c, msk);
         end
      end else if ((m_beats.size() != 0) && go) begin
         m_last_data = m_beats[0].data;
         void'(m_beats.pop_front());
         if (m_beats.size() == 0) m_delivered++;
      end
   endtask

   task automatic model_clear();
      m_decode_pending = 1'b0;
      m_beats.delete();
      m_last_data = '0;
      m_delivered = '0;
      m_dropped   = '0;
   endtask

   task automatic push_word(input logic [DIW-1:0] w, input logic [RW-1:0] r, input logic [CW-1:0] c);
      tag_t t;
      t.r = r;
      t.c = c;
      data_q.push_back(w);
      tag_q.push_back(t);
   endtask

   // Run until the FIFOs and the model are empty, within a cycle budget.
   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((n < bound) && ((data_q.size() != 0) || (tag_q.size() != 0) || model_in_flight())) begin
         step();
         n++;
      end
      check("drain_timeout", {63'd0, model_in_flight()}, 64'd0);
   endtask

   initial begin
      logic [CNTW-1:0] d0;
      logic [CNTW-1:0] p0;
      tag_t            t;

      word_no  = 0;
      row_id   = 4'd2;
      for (int i = 0; i < NP; i++) col_arr[i] = CW'(i);
      pe_ready = '1;
      model_clear();
      drive_heads();

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pe_we", pe_we, 0);
      check("reset_busy", busy, 0);
      check("reset_pe_data", pe_data, 0);
      check("reset_delivered", delivered_count, 0);
      check("reset_dropped", dropped_count, 0);
      reset = 1'b0;

      // Single match to PE 3
      push_word(64'h0004_0003_0002_0001, 4'd2, 4'd3);
      repeat (7) step();
      check("single_delivered", delivered_count, 1);
      check("single_last_data", pe_data, 16'h0004);

      // Row mismatch is dropped after pop + decode
      push_word(64'h1111_2222_3333_4444, 4'd5, 4'd3);
      repeat (2) step();
      #1;
      check("mismatch_idle", busy, 0);
      check("mismatch_dropped", dropped_count, 1);
      step();

      // Multicast to PEs 1 and 4 with PE 4 stalling three cycles; PE 0 not ready is ignored
      col_arr[1] = 4'd7;
      col_arr[4] = 4'd7;
      col_arr[7] = 4'd1;
      push_word(64'hAAAA_BBBB_CCCC_DDDD, 4'd2, 4'd7);
      pe_ready = '1;
      pe_ready[4] = 1'b0;
      pe_ready[0] = 1'b0;
      repeat (5) step();
      pe_ready[4] = 1'b1;
      repeat (5) step();
      pe_ready = '1;
      check("multicast_delivered", delivered_count, 2);

      // FIFO skew: data present without a tag must not pop
      data_q.push_back(64'h0123_4567_89AB_CDEF);
      repeat (5) step();
      t.r = 4'd2;
      t.c = 4'd5;
      tag_q.push_back(t);
      drain(20);

      // Reset in the middle of SEND, after beat 1
      push_word(64'h5555_6666_7777_8888, 4'd2, 4'd5);
      repeat (4) step();
      reset = 1'b1;
      #1;
      check("midreset_pe_we", pe_we, 0);
      check("midreset_busy", busy, 0);
      check("midreset_delivered", delivered_count, 0);
      check("midreset_dropped", dropped_count, 0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
      push_word(64'h9999_AAAA_BBBB_CCCC, 4'd2, 4'd6);
      drain(20);
      check("after_reset_delivered", delivered_count, 1);

      // All-ones tags: wildcard when the feature is built in, otherwise dropped
      d0 = delivered_count;
      p0 = dropped_count;
      push_word(64'hF00D_BEEF_CAFE_1234, 4'hF, 4'hF);
      drain(20);
      check("bcast_delivered", delivered_count, d0 + CNTW'(BCAST));
      check("bcast_dropped", dropped_count, p0 + CNTW'(!BCAST));

      // Random traffic with skewed FIFO fills, backpressure and ID changes
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ((cyc % 64) == 0) begin
            row_id = RW'($urandom_range(0, 14));
            for (int i = 0; i < NP; i++) col_arr[i] = CW'($urandom_range(0, 7));
         end
         if ((gen_data.size() < 2) && ($urandom_range(0, 2) == 0)) begin
            gen_data.push_back({$urandom, $urandom});
            case ($urandom_range(0, 3))
               0, 1:    t.r = row_id;
               2:       t.r = RW'($urandom_range(0, 15));
               default: t.r = 4'hF;
            endcase
            t.c = ($urandom_range(0, 7) == 7) ? 4'hF : CW'($urandom_range(0, 7));
            gen_tag.push_back(t);
         end
         if ((gen_data.size() != 0) && ($urandom_range(0, 3) != 0)) data_q.push_back(gen_data.pop_front());
         if ((gen_tag.size() != 0) && ($urandom_range(0, 3) != 0)) tag_q.push_back(gen_tag.pop_front());
         for (int i = 0; i < NP; i++) pe_ready[i] = ($urandom_range(0, 4) != 0);
         step();
      end
      while (gen_data.size() != 0) data_q.push_back(gen_data.pop_front());
      while (gen_tag.size() != 0) tag_q.push_back(gen_tag.pop_front());
      pe_ready = '1;
      drain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/filter_gin_receiver.md
Name: filter_gin_receiver

Overview:
- Receiving end of the filter global input network (GIN) for one PE row.
- Pops 64-bit packed filter words and their row/col tags from the GIN data and tag FIFOs (first-word-fall-through) and matches the tags against this row's ID and each PE's column ID.
- Unpacks each matched word into 16-bit weights and multicasts them to the filter scratchpad write port of every matching PE, under per-PE backpressure.
- Unmatched words are popped and dropped.

Parameters:
- DATA_IN_WIDTH, 64, packed GIN word width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 16, weight width delivered to a PE.
- ROW_TAG_WIDTH, 4, row tag / row ID width.
- COL_TAG_WIDTH, 4, col tag / PE column ID width.
- NUM_PE, 14, PEs served in this row.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-high.
- row_id  in  ROW_TAG_WIDTH  this row's ID; quasi-static.
- col_ids  in  NUM_PE*COL_TAG_WIDTH  PE i's column ID in bits [i*COL_TAG_WIDTH +: COL_TAG_WIDTH]; quasi-static.
- gin_fifo_empty  in  1  GIN data FIFO empty.
- gin_data  in  DATA_IN_WIDTH  FWFT head of the GIN data FIFO.
- tags_fifo_empty  in  1  tag FIFO empty.
- row_tag  in  ROW_TAG_WIDTH  FWFT head row tag.
- col_tag  in  COL_TAG_WIDTH  FWFT head col tag.
- re_from_gin_fifo  out  1  pop strobe, driven to both FIFOs together.
- pe_ready  in  NUM_PE  PE i's filter scratchpad can accept a write.
- pe_we  out  NUM_PE  per-PE write enable.
- pe_data  out  DATA_OUT_WIDTH  shared weight bus.
- busy  out  1  high whenever the FSM is not IDLE.
- delivered_count  out  CNT_WIDTH  number of words fully delivered.
- dropped_count  out  CNT_WIDTH  number of words that matched no PE.

Behaviour:
- Derived constants:
  - RATIO = DATA_IN_WIDTH/DATA_OUT_WIDTH (default 4).
  - Beat counter width = max(1, $clog2(RATIO)).
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; all outputs and counters go to 0; latched word, tags and mask are cleared.
  - Reset mid-SEND discards the remaining beats. The word was already popped and is lost.
- IDLE:
  - If !gin_fifo_empty && !tags_fifo_empty: re_from_gin_fifo=1 for exactly this cycle; latch gin_data, row_tag and col_tag at the same edge; go to DECODE.
  - If only one FIFO is non-empty, wait. No pop.
- DECODE (1 cycle):
  - mask[i] = (row_tag_q==row_id) && (col_tag_q==col_ids[i]); mask is registered.
  - If mask==0: dropped_count++ and go to IDLE.
  - Otherwise: beat=0 and go to SEND.
- SEND:
  - Define go = &(pe_ready | ~mask).
  - When go=1: pe_we=mask; pe_data=word_q[beat*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] (LSB slice first); beat++.
  - When go=0: stall with pe_we=0, beat held, pe_data held.
  - A non-targeted PE's pe_ready is ignored.
  - On the beat with beat==RATIO-1 and go=1: delivered_count++ and go to IDLE.
- Throughput: at best 1+1+RATIO cycles per word, no overlap. No pop occurs outside IDLE.
- Counters wrap modulo 2^CNT_WIDTH.
- busy = (state != IDLE).
- pe_we is 0 outside SEND. pe_data retains its last value outside SEND.
- row_id/col_ids are sampled only in DECODE. Changing them mid-word affects only later words.
- Duplicate col_ids are legal: all PEs with that ID receive the data (multicast).

Optional Feature:
- Macro: FILTER_GIN_BROADCAST_EN.
- When defined:
  - col_tag of all ones matches every PE whose row matches, regardless of col_ids.
  - row_tag of all ones matches any row_id.
- When undefined: an all-ones tag is an ordinary value compared literally.

Decomposition:
- Shared package filter_gin_pkg:
  - state enum {IDLE, DECODE, SEND};
  - RATIO and beat-width localparam functions;
  - BCAST_ROW/BCAST_COL all-ones constants.
- One sub-module, gin_tag_matcher: combinational NUM_PE-wide mask generation from tags, row_id and col_ids. It includes the broadcast logic under the macro.
- The FSM, unpacker and counters stay in the top module.

Test Plan:
- Single match:
  - Stimulus: row_id=2, col_ids[3]=3, word 0x0004_0003_0002_0001 with tags (2,3), all pe_ready=1.
  - Response: one pop, then pe_we[3] only for 4 consecutive cycles with pe_data 0x0001, 0x0002, 0x0003, 0x0004; delivered_count=1.
- Row mismatch:
  - Stimulus: tags (5,3) with row_id=2.
  - Response: pop, pe_we stays 0, dropped_count=1, back to IDLE after 2 cycles.
- Multicast with backpressure:
  - Stimulus: col_ids[1]=col_ids[4]=7, tags (row_id,7), pe_ready[4]=0 for 3 cycles after SEND entry.
  - Response: no writes for 3 cycles, then 4 beats with pe_we = bits 1 and 4 set; pe_ready[0]=0 has no effect.
- FIFO skew:
  - Stimulus: gin_fifo_empty=0, tags_fifo_empty=1 for 5 cycles.
  - Response: no pop. The pop occurs on the first cycle both FIFOs are non-empty.
- Reset mid-SEND:
  - Stimulus: assert reset after beat 1.
  - Response: pe_we=0 and busy=0 immediately (asynchronously); counters=0; the next word is delivered from beat 0.
- Broadcast (FILTER_GIN_BROADCAST_EN defined):
  - Stimulus: tags (4'hF, 4'hF).
  - Response: pe_we = all ones for 4 beats. With the macro undefined and no ID equal to 0xF, the word is dropped.
